// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host bridge.
// Optional timeout/abort path is enabled with the macro WB_HOST_TIMEOUT_EN.
package wb_host_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_SELW = 4;

  // Read data reported with an aborted transfer
  localparam logic [WB_DW-1:0] RSP_ERR_DAT = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Command payload as it is held on the Wishbone outputs
  typedef struct packed {
    logic               we;
    logic [WB_SELW-1:0] sel;
    logic [WB_AW-1:0]   adr;
    logic [WB_DW-1:0]   dat;
  } wb_cmd_t;

  // Response data for a completed (acknowledged) transfer: writes return zero
  function automatic logic [WB_DW-1:0] ack_rsp_data(input logic we,
                                                    input logic [WB_DW-1:0] rd);
    return we ? WB_DW'(0) : rd;
  endfunction

endpackage

// File: rtl/wb_host_bridge_timeout.sv
// Bus-cycle timeout counter for the Wishbone host bridge.
// Instantiated only when WB_HOST_TIMEOUT_EN is defined.
module wb_host_timeout #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Counts cycles spent waiting for an acknowledge; cleared on each new command
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Last allowed wait cycle: the bus is held for exactly TIMEOUT cycles
  assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_bridge.sv
// Wishbone classic single-transfer initiator: valid/ready command stream in,
// one bus cycle per command, valid/ready response stream out.
// Define WB_HOST_TIMEOUT_EN to build the ack timeout and abort path.
module wb_host_bridge
  import wb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned STAT_W  = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_SELW-1:0] cmd_sel,
  input  logic [WB_AW-1:0]   cmd_adr,
  input  logic [WB_DW-1:0]   cmd_dat,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  output logic [STAT_W-1:0]  xfer_cnt,
  output logic [STAT_W-1:0]  err_cnt
);

  // Reject an unusable timeout setting at elaboration
  if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
    $error("wb_host_bridge: TIMEOUT out of range for CNT_W");
  end

  state_e  state;
  state_e  next_state;
  wb_cmd_t cmd_q;
  logic    cyc_q;
  logic    accept_c;
  logic    ack_c;
  logic    tmo_c;

  assign accept_c = (state == IDLE) && cmd_ready && cmd_valid;
  assign ack_c    = (state == BUS) && wbm_ack_i;

`ifdef WB_HOST_TIMEOUT_EN
  logic expired;

  wb_host_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (accept_c),
    .run     (state == BUS),
    .expired (expired)
  );

  // An acknowledge in the final wait cycle takes priority over the abort
  assign tmo_c = (state == BUS) && !wbm_ack_i && expired;
`else
  assign tmo_c = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c)       next_state = BUS;
      BUS:     if (ack_c || tmo_c) next_state = RESP;
      RESP:    if (rsp_ready)      next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // Handshake flags follow the state being entered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
    end
  end

  // Bus-side registers: command is latched at accept and held afterwards
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_q <= '0;
      cyc_q <= 1'b0;
    end else if (accept_c) begin
      cmd_q <= '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
      cyc_q <= 1'b1;
    end else if (ack_c || tmo_c) begin
      cyc_q <= 1'b0;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cmd_q.we;
  assign wbm_sel_o = cmd_q.sel;
  assign wbm_adr_o = cmd_q.adr;
  assign wbm_dat_o = cmd_q.dat;

  // Response capture at the end of the bus cycle, held through RESP
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else if (ack_c) begin
      rsp_dat <= ack_rsp_data(cmd_q.we, wbm_dat_i);
      rsp_err <= 1'b0;
    end else if (tmo_c) begin
      rsp_dat <= RSP_ERR_DAT;
      rsp_err <= 1'b1;
    end
  end

  // Completed-transfer counter, wraps naturally
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      xfer_cnt <= '0;
    end else if (ack_c || tmo_c) begin
      xfer_cnt <= xfer_cnt + STAT_W'(1);
    end
  end

`ifdef WB_HOST_TIMEOUT_EN
  logic [STAT_W-1:0] err_q;

  // Timed-out transfer counter, wraps naturally
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q <= '0;
    end else if (tmo_c) begin
      err_q <= err_q + STAT_W'(1);
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_host_bridge.sv
// Self-checking bench for wb_host_bridge: table-driven transfers against a
// wait-state slave model, scoreboarded responses, plus backpressure,
// minimum-period, mid-transfer reset and counter-wrap sequences.
module tb_wb_host_bridge;

  localparam int unsigned TMO  = 8;
  localparam int unsigned SW   = 4;
  localparam int unsigned NVEC = 8;
`ifdef WB_HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          wt;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we_o, ack;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [SW-1:0] xfer_cnt, err_cnt;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  vec_t        vec[NVEC];
  vec_t        none;
  int          exp_xfer = 0;
  int          exp_errc = 0;
  int          cyc_total = 0;
  int          cyc_start = 0;
  int          scnt = 0;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        cur_we = 1'b0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] cur_adr = '0, cur_dat = '0;

  wb_host_bridge #(.TIMEOUT(TMO), .CNT_W(8), .STAT_W(SW)) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),   .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),  .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),  .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),      .wbm_stb_o(stb),
    .wbm_we_o (we_o),     .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o),    .wbm_dat_o(dat_o),
    .wbm_ack_i(ack),      .wbm_dat_i(dat_i),
    .xfer_cnt (xfer_cnt), .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Slave model: acknowledges after slv_wait wait states
  assign ack   = cyc && stb && (scnt == slv_wait);
  assign dat_i = ack ? slv_rdata : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (cyc && !ack) scnt <= scnt + 1;
    else             scnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: cyc==stb always, outputs equal the accepted command while cyc
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_eq_stb", 32'(cyc), 32'(stb));
      if (cyc === 1'b1) begin
        cyc_total++;
        chk("wbm_adr", adr_o, cur_adr);
        chk("wbm_dat", dat_o, cur_dat);
        chk("wbm_we", 32'(we_o), 32'(cur_we));
        chk("wbm_sel", 32'(sel_o), 32'(cur_sel));
      end
    end
  end

  task automatic drive(input vec_t v);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_sel = v.sel; cmd_adr = v.adr; cmd_dat = v.dat;
    cur_we = v.we; cur_sel = v.sel; cur_adr = v.adr; cur_dat = v.dat;
    slv_wait = v.wt; slv_rdata = v.rdata;
    sb.push_back('{v.exp_dat, v.exp_err, v.exp_len});
  endtask

  // Called #1 after the accept edge: drop valid and scramble the command bus
  task automatic post_accept();
    cyc_start = cyc_total;
    cmd_valid = 1'b0;
    cmd_we  = 1'($urandom);
    cmd_sel = 4'($urandom);
    cmd_adr = $urandom;
    cmd_dat = $urandom;
  endtask

  task automatic issue(input vec_t v);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("issue_ready", 32'(cmd_ready), 32'd1);
    drive(v);
    @(posedge clk); #1;
    post_accept();
  endtask

  task automatic collect(input int hold, input bit offer, input vec_t nxt);
    int   lat = 0;
    exp_t e;
    do begin @(negedge clk); lat++; end while (rsp_valid !== 1'b1 && lat < 300);
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    exp_xfer = (exp_xfer + 1) % (1 << SW);
    if (e.err) exp_errc = (exp_errc + 1) % (1 << SW);
    chk("rsp_latency", lat, e.len + 1);
    chk("cyc_len", cyc_total - cyc_start, e.len);
    chk("cyc_low_in_resp", 32'(cyc), 32'd0);
    chk("rsp_dat", rsp_dat, e.dat);
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    chk("xfer_cnt", 32'(xfer_cnt), exp_xfer);
    chk("err_cnt", 32'(err_cnt), exp_errc);
    if (offer) drive(nxt);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_dat", rsp_dat, e.dat);
      chk("hold_err", 32'(rsp_err), 32'(e.err));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_no_cyc", 32'(cyc), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (offer) begin
      @(negedge clk);
      chk("offer_ready_after", 32'(cmd_ready), 32'd1);
      chk("offer_not_yet", 32'(cyc), 32'd0);
      @(posedge clk); #1;
      post_accept();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    none = '{default: '0};
    //           we  sel    adr            dat            rdata          wt  exp_dat                          err    len
    vec[0] = '{1'b1, 4'hF, 32'h3000_0000, 32'h0000_00A5, 32'h5555_AAAA, 0,  32'h0,                           1'b0,  1};
    vec[1] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0,         32'h1234_5678, 3,  32'h1234_5678,                   1'b0,  4};
    vec[2] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0,         32'h0BAD_F00D, 20, TO_EN ? 32'h0 : 32'h0BAD_F00D,  TO_EN, TO_EN ? 8 : 21};
    vec[3] = '{1'b0, 4'hF, 32'h3000_000C, 32'h0,         32'h8765_4321, 7,  32'h8765_4321,                   1'b0,  8};
    vec[4] = '{1'b1, 4'h1, 32'h3000_0010, 32'hFFFF_0001, 32'h7777_7777, 20, 32'h0,                           TO_EN, TO_EN ? 8 : 21};
    vec[5] = '{1'b0, 4'h3, 32'h3000_0014, 32'h0,         32'hCAFE_F00D, 1,  32'hCAFE_F00D,                   1'b0,  2};
    vec[6] = '{1'b1, 4'hC, 32'h3000_0018, 32'hA5A5_5A5A, 32'h1111_2222, 2,  32'h0,                           1'b0,  3};
    vec[7] = '{1'b0, 4'h8, 32'h3000_001C, 32'h0,         32'h0F0F_F0F0, 6,  32'h0F0F_F0F0,                   1'b0,  7};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Table-driven transfers
    for (int i = 0; i < NVEC; i++) begin
      issue(vec[i]);
      collect(0, 1'b0, none);
    end

    // Backpressure with a command offered while the response is held
    issue(vec[1]);
    collect(10, 1'b1, vec[5]);
    collect(0, 1'b0, none);

    // Minimum command-to-command period with a zero-wait slave
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0000_0042;
    cur_we = 1'b1; cur_sel = 4'hF; cur_adr = 32'h3000_0020; cur_dat = 32'h0000_0042;
    slv_wait = 0; slv_rdata = 32'h9999_9999;
    rsp_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready === 1'b1 && cmd_valid) accepts++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    exp_xfer = (exp_xfer + 4) % (1 << SW);
    chk("min_period_accepts", accepts, 4);
    chk("min_period_xfer", 32'(xfer_cnt), exp_xfer);

    // Reset in the middle of a bus cycle
    issue(vec[2]);
    repeat (3) @(negedge clk);
    chk("mid_cyc_high", 32'(cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(cyc), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    sb.delete();
    exp_xfer = 0;
    exp_errc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    issue(vec[1]);
    collect(0, 1'b0, none);

    // Status counter wrap: 16 transfers since reset returns to zero
    for (int i = 0; i < 15; i++) begin
      issue(vec[i % 2 == 0 ? 0 : 5]);
      collect(0, 1'b0, none);
    end
    chk("wrap_zero", 32'(xfer_cnt), 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_host_bridge.md
# wb_host_bridge

Wishbone classic single-transfer initiator. It converts a valid/ready command stream into Wishbone read and write cycles on the user-area slave bus, and returns read data and status through a valid/ready response stream. It sits between an on-chip command source (LA-driven sequencer or test harness) and Wishbone slaves such as the user-project counter. It is the initiator-side counterpart to our slave blocks.

## Interface
Parameters:
- TIMEOUT, 255: bus cycles to wait for `wbm_ack_i` before aborting; range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.
- STAT_W, 16: width of the transfer and error counters.

Ports:
- wb_clk_i  in  1  the single clock; all logic is rising-edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the bridge can accept a command; high only in IDLE.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte selects.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- rsp_valid  out  1  a response is pending.
- rsp_ready  in  1  the consumer takes the response.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  the transfer timed out.
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle and strobe; always equal.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.
- xfer_cnt  out  STAT_W  count of completed transfers.
- err_cnt  out  STAT_W  count of timed-out transfers.

## Operation
- FSM states are IDLE, BUS and RESP.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid` the command is registered onto the `wbm_*` outputs, and cyc and stb are set. The FSM moves to BUS.
- **BUS:**
  - cyc, stb and all `wbm_*` outputs are held stable.
  - The timeout counter increments each cycle.
  - On `wbm_ack_i`, capture `rsp_dat` (`wbm_dat_i` for reads, 0 for writes). Clear cyc and stb, set `rsp_err` = 0, increment `xfer_cnt`, and go to RESP.
  - If the counter reaches TIMEOUT-1 without an ack: clear cyc and stb, set `rsp_err` = 1 and `rsp_dat` = 0, increment both `xfer_cnt` and `err_cnt`, and go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- **RESP:**
  - `rsp_valid` = 1, and `rsp_dat` and `rsp_err` are held.
  - On `rsp_ready`, go to IDLE.
- Status counters wrap modulo 2^STAT_W.
- `wbm_ack_i` is ignored outside BUS.
- After the ack, `wbm_adr_o`, `wbm_dat_o`, `wbm_we_o` and `wbm_sel_o` keep their last values (don't-care to slaves).

## Timing
- **Reset values:** `cmd_ready` = 0 during reset and 1 the cycle after. `rsp_valid`, `rsp_err`, `rsp_dat`, cyc, stb, all `wbm_*` outputs, `xfer_cnt` and `err_cnt` are all 0. The FSM is in IDLE.
- **Accept:** the accept edge is cycle 0. cyc and stb are high from cycle 1.
- **Acknowledge:** an ack sampled at edge N drops cyc and stb and raises `rsp_valid` at N+1.
  - Minimum command-to-command period is 3 cycles: a zero-wait slave plus `rsp_ready` held high.
- **Timeout:** cyc and stb stay high for exactly TIMEOUT cycles.
- **Reset mid-transfer:** at the reset edge, cyc and stb drop and any pending response and the counter state are discarded. No response is generated.
- `cmd_*` inputs are sampled only at the accept edge. Later changes have no effect.

## Configuration
- Macro: `WB_HOST_TIMEOUT_EN`.
- **Defined:** the timeout counter and abort path are built as described above.
- **Undefined:**
  - No counter exists. BUS waits indefinitely for ack.
  - `rsp_err` and `err_cnt` are tied to 0.
  - TIMEOUT and CNT_W are unused.

## Structure
- Package `wb_host_pkg` holds:
  - the state enum type (IDLE, BUS, RESP);
  - constants `WB_DW` = 32, `WB_AW` = 32 and `WB_SELW` = 4;
  - `RSP_ERR_DAT` = 32'h0.
- One sub-module, `wb_host_timeout`, built only under `WB_HOST_TIMEOUT_EN`.
  - Inputs: `clr` and `run`. Output: `expired`.
  - Internal counter: CNT_W bits, synchronous reset.

## Test plan
- **Write, zero-wait slave:** cmd we=1, adr=0x3000_0000, dat=0x0000_00A5, sel=0xF.
  - The `wbm_*` outputs match for exactly 1 cycle of cyc and stb.
  - `rsp_valid` appears 2 cycles after accept with `rsp_err`=0 and `rsp_dat`=0. `xfer_cnt`=1.
- **Read, 3-wait slave:** returns 0x1234_5678.
  - cyc and stb are high for 4 cycles.
  - `rsp_dat`=0x1234_5678 and `rsp_err`=0.
- **Timeout:** TIMEOUT=8, no ack.
  - cyc and stb are high for exactly 8 cycles.
  - `rsp_err`=1, `rsp_dat`=0, `err_cnt`=1.
  - Repeat with ack on the 8th cycle: `rsp_err`=0 (ack wins).
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles.
  - `rsp_valid` and data stay stable; `cmd_ready`=0 throughout.
  - A `cmd_valid` offered during this time is not accepted until 1 cycle after `rsp_ready`.
- **Reset mid-BUS:** assert `wb_rst_i` while cyc is high.
  - The next cycle shows cyc=0, `rsp_valid`=0 and counters=0.
  - A subsequent read completes normally.
- **Counter wrap:** STAT_W=4, 16 transfers -> `xfer_cnt` returns to 0.
